dm_byte_clr: RTL
================

DM_BYTE_CLR -- requirements
Module: dm_byte_clr

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, number of 32-bit words.
REQ-002 SHALL have parameter IDX_W, default 12, word-index width; DEPTH <= 2**IDX_W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; reset==0 at a rising clk edge resets.
REQ-005 SHALL have port A  input  32  byte address; word index = A[IDX_W+1:2].
REQ-006 SHALL have port WD  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 SHALL have port PC_M  input  32  PC of the accessing instruction, used only for the write log.
REQ-008 SHALL have port WE  input  1  store request.
REQ-009 SHALL have port RE  input  1  load request.
REQ-010 SHALL have port OP  input  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 illegal.
REQ-011 SHALL have port RD  output  32  load result, extended per OP.
REQ-012 SHALL have port busy  output  1  clear sequence in progress.
REQ-013 SHALL have port exc_adel  output  1  load address error.
REQ-014 SHALL have port exc_ades  output  1  store address error.

Function
REQ-015 SHALL implement FSM states CLEAR and IDLE; busy = (state==CLEAR).
REQ-016 SHALL, in CLEAR, write 0 to word cnt each cycle after reset deasserts, increment cnt, and enter IDLE the cycle after clearing word DEPTH-1 (DEPTH busy cycles after release).
REQ-017 SHALL hold state=CLEAR, cnt=0 while reset==0; reset reasserted mid-clear restarts from word 0.
REQ-018 SHALL ignore WE and force RD=0, exc_adel=0, exc_ades=0 while busy.
REQ-019 SHALL flag misalignment: word with A[1:0]!=0, half with A[0]!=0; bytes never misaligned.
REQ-020 SHALL flag out-of-range: word index >= DEPTH, or OP illegal.
REQ-021 SHALL set exc_adel = RE & !busy & (misaligned | out-of-range), combinationally.
REQ-022 SHALL set exc_ades = WE & !busy & (misaligned | out-of-range), combinationally.
REQ-023 SHALL suppress the write when exc_ades=1; memory unchanged.
REQ-024 SHALL, on a valid store, update only addressed lanes at the clock edge: word all 4; half lanes A[1]*2..+1; byte lane A[1:0]; other bytes preserved.
REQ-025 SHALL read combinationally (zero latency) from the current array contents; a store and load to the same word in one cycle returns pre-store data.
REQ-026 SHALL select half by A[1], byte by A[1:0]; zero-extend for OP 001/011, sign-extend for OP 010/100.
REQ-027 SHALL drive RD=0 when RE=0 or exc_adel=1.
REQ-028 SHALL log each valid store via $display "@%h: *%h <= %h" with PC_M, word-aligned address {A[31:2],2'b00}, and the full merged word after the store.
REQ-029 SHALL NOT log clear-sequence writes or suppressed stores.
REQ-030 SHALL treat WE=1 and RE=1 together as independent store and load; both exceptions may assert.

Reset
REQ-031 SHALL, on reset==0 at a clk edge, set state=CLEAR, cnt=0; busy=1 from that edge.
REQ-032 SHALL hold RD=0, exc_adel=0, exc_ades=0 during reset and the following clear sequence.
REQ-033 SHALL have all DEPTH words read 0 once busy falls.

Verification
REQ-034 Reset low 2 cycles, release -> busy=1 for exactly DEPTH cycles, then 0; load A=0x0000_2FFC, OP=000 -> RD=0.
REQ-035 Store word A=0x10 WD=0x1122_3344, then store byte A=0x11 WD=0xAB -> load word A=0x10 reads 0x1122_AB44; log "@<pc>: *00000010 <= 1122ab44".
REQ-036 Word 0x10 = 0x80FF_7F01: load OP=100 A=0x12 -> 0xFFFF_FFFF; OP=011 A=0x12 -> 0x0000_00FF; OP=010 A=0x12 -> 0xFFFF_80FF; OP=001 A=0x10 -> 0x0000_7F01.
REQ-037 Store half A=0x13 -> exc_ades=1, word unchanged, no log; load word A=0x0000_3000 (DEPTH=3072) -> exc_adel=1, RD=0.
REQ-038 Reset reasserted at clear cycle 100, released -> busy restarts, lasts DEPTH cycles; store issued while busy has no effect.

Source files
------------

// File: rtl/dm_byte_clr.sv
// dm_byte_clr: word-organised data memory with byte/half/word access and a self-clearing sequence after reset.
// Latency: loads are combinational (zero cycles); stores and clear writes take effect at the rising clk edge.
// Backpressure: busy is high while the clear sequence runs; stores are dropped and load outputs are held at 0.
//
// Ports:
//   clk       single clock, all state changes on its rising edge
//   reset     synchronous active-low reset
//   A         byte address; word index = A[IDX_W+1:2]
//   WD        right-aligned store data
//   PC_M      PC of the accessing instruction (store log only)
//   WE / RE   store / load request
//   OP        000 word, 001 half u, 010 half s, 011 byte u, 100 byte s; 101-111 illegal
//   RD        load result, zero/sign-extended per OP
//   busy      clear sequence in progress
//   exc_adel  load address error (combinational)
//   exc_ades  store address error (combinational)
module dm_byte_clr #(
  parameter int DEPTH = 3072,
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [31:0] PC_M,
  input  logic        WE,
  input  logic        RE,
  input  logic [2:0]  OP,
  output logic [31:0] RD,
  output logic        busy,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_HU = 3'b001;
  localparam logic [2:0] OP_HS = 3'b010;
  localparam logic [2:0] OP_BU = 3'b011;
  localparam logic [2:0] OP_BS = 3'b100;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_EXT = (IDX_W + 1)'(DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_nxt;
  logic             clr_en;

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             op_legal;
  logic             misalign;
  logic             addr_err;
  logic [31:0]      cur_word;
  logic [31:0]      merged;
  logic             wr_ok;
  logic [15:0]      half_sel;
  logic [7:0]       byte_sel;
  logic [31:0]      rd_val;
  logic             rd_ok;

  // ---------------------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    case (state)
      CLEAR: begin
        // Held in reset, cnt stays at 0 and nothing is written; each
        // released cycle zeroes one word.
        if (reset) begin
          clr_en  = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state_nxt = IDLE;
          end
        end
      end
      IDLE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign busy = (state == CLEAR);

  // ---------------------------------------------------------------------------
  // Address decode and error flags
  // ---------------------------------------------------------------------------
  assign idx      = A[IDX_W+1:2];
  assign in_range = ({1'b0, idx} < DEPTH_EXT);
  assign op_legal = (OP <= OP_BS);

  always_comb begin
    misalign = 1'b0;
    case (OP)
      OP_W:           misalign = (A[1:0] != 2'b00);
      OP_HU, OP_HS:   misalign = A[0];
      default:        misalign = 1'b0;
    endcase
  end

  assign addr_err = misalign | ~in_range | ~op_legal;
  assign exc_adel = RE & ~busy & addr_err;
  assign exc_ades = WE & ~busy & addr_err;

  // Out-of-range indices never reach the array.
  assign cur_word = in_range ? mem[idx] : 32'h0;

  // ---------------------------------------------------------------------------
  // Store merge: replace only the addressed lanes of the current word
  // ---------------------------------------------------------------------------
  always_comb begin
    merged = cur_word;
    case (OP)
      OP_W: begin
        merged = WD;
      end
      OP_HU, OP_HS: begin
        if (A[1]) merged[31:16] = WD[15:0];
        else      merged[15:0]  = WD[15:0];
      end
      OP_BU, OP_BS: begin
        case (A[1:0])
          2'd0:    merged[7:0]   = WD[7:0];
          2'd1:    merged[15:8]  = WD[7:0];
          2'd2:    merged[23:16] = WD[7:0];
          default: merged[31:24] = WD[7:0];
        endcase
      end
      default: begin
        merged = cur_word;
      end
    endcase
  end

  assign wr_ok = WE & ~busy & ~addr_err;

  // Clear writes and stores are mutually exclusive: stores are dropped while busy.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[cnt] <= 32'h0;
    end else if (wr_ok) begin
      mem[idx] <= merged;
      $display("@%h: *%h <= %h", PC_M, {A[31:2], 2'b00}, merged);
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: reads the pre-edge contents, so a same-cycle store is not visible
  // ---------------------------------------------------------------------------
  assign half_sel = A[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    byte_sel = cur_word[7:0];
    case (A[1:0])
      2'd0:    byte_sel = cur_word[7:0];
      2'd1:    byte_sel = cur_word[15:8];
      2'd2:    byte_sel = cur_word[23:16];
      default: byte_sel = cur_word[31:24];
    endcase
  end

  always_comb begin
    rd_val = 32'h0;
    case (OP)
      OP_W:    rd_val = cur_word;
      OP_HU:   rd_val = {16'h0, half_sel};
      OP_HS:   rd_val = {{16{half_sel[15]}}, half_sel};
      OP_BU:   rd_val = {24'h0, byte_sel};
      OP_BS:   rd_val = {{24{byte_sel[7]}}, byte_sel};
      default: rd_val = 32'h0;
    endcase
  end

  assign rd_ok = RE & ~busy & ~addr_err;
  assign RD    = rd_ok ? rd_val : 32'h0;

endmodule
